// File: rtl/burst_ram.sv
// Single-port burst RAM on a shared tri-state bus with a wrapping address counter, wait states and abort.
// Optional stored even parity with a sticky read error flag: define BURST_RAM_PARITY_EN.
module burst_ram #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1,
  parameter int LEN_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              abort,
  inout  wire  [DATA_W-1:0] bus,
  output logic              busy,
  output logic              ready,
  output logic              last,
  output logic              parity_err
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef BURST_RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              dir_q, dir_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic [3:0]        wait_q, wait_d;
  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic [MEM_W-1:0]  rd_word;
  logic [MEM_W-1:0]  wr_word;
  logic              wr_en;
  logic              drive_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      dir_q   <= 1'b0;
      beats_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dir_q   <= dir_d;
      beats_q <= beats_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dir_d   = dir_q;
    beats_d = beats_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        // abort wins over a simultaneous start
        if (start && !abort) begin
          ptr_d   = addr;
          dir_d   = wr;
          beats_d = burst_len;
          wait_d  = WAIT_LOAD;
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_XFER;
        end
      end
      S_WAIT: begin
        if (abort)              state_d = S_IDLE;
        else if (wait_q == 4'd0) state_d = S_XFER;
        else                    wait_d  = wait_q - 4'd1;
      end
      S_XFER: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          ptr_d   = ptr_q + ADDR_W'(1);
          beats_d = beats_q - LEN_W'(1);
          if (beats_q == '0) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign ready    = (state_q == S_XFER);
  assign last     = ready && (beats_q == '0);
  assign drive_en = ready && !dir_q;
  assign wr_en    = ready && dir_q && !abort;

  assign rd_word = mem_q[ptr_q];
  assign bus     = drive_en ? rd_word[DATA_W-1:0] : 'z;

  // Memory is never reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[ptr_q] <= wr_word;
  end

`ifdef BURST_RAM_PARITY_EN
  logic perr_q;
  assign wr_word = {^bus, bus};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         perr_q <= 1'b0;
    else if (drive_en && ^rd_word)   perr_q <= 1'b1;
  end
  assign parity_err = perr_q;
`else
  assign wr_word    = bus;
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_burst_ram.sv
// Scoreboard bench for burst_ram: one instance with one wait state, one with none.
module tb_burst_ram;

  typedef struct packed {
    logic [31:0] data;
    logic        chk;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_s [2];
  logic        wr_s    [2];
  logic [9:0]  addr_s  [2];
  logic [3:0]  len_s   [2];
  logic        abort_s [2];
  logic        drv_s   [2];
  logic [31:0] dval_s  [2];
  wire  [31:0] bus0, bus1;
  logic        busy0, ready0, last0, perr0;
  logic        busy1, ready1, last1, perr1;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pulldown (bus0);
  pulldown (bus1);
  assign bus0 = drv_s[0] ? dval_s[0] : 'z;
  assign bus1 = drv_s[1] ? dval_s[1] : 'z;

  burst_ram #(.DATA_W(32), .ADDR_W(10), .WAIT_STATES(1), .LEN_W(4)) dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .wr(wr_s[0]), .addr(addr_s[0]),
    .burst_len(len_s[0]), .abort(abort_s[0]), .bus(bus0), .busy(busy0),
    .ready(ready0), .last(last0), .parity_err(perr0));

  burst_ram #(.DATA_W(32), .ADDR_W(10), .WAIT_STATES(0), .LEN_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .wr(wr_s[1]), .addr(addr_s[1]),
    .burst_len(len_s[1]), .abort(abort_s[1]), .bus(bus1), .busy(busy1),
    .ready(ready1), .last(last1), .parity_err(perr1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bus_of(input int k);
    return (k == 0) ? bus0 : bus1;
  endfunction
  function automatic logic busy_of(input int k);
    return (k == 0) ? busy0 : busy1;
  endfunction
  function automatic logic ready_of(input int k);
    return (k == 0) ? ready0 : ready1;
  endfunction

  // Monitors: every ready beat consumes one expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ready0) begin
      if (q0.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_beat0: got ready=1 expected no beat at %0t", $time);
      end else begin
        e = q0.pop_front();
        chk("last0", 32'(last0), 32'(e.last));
        if (e.chk) chk("rd_data0", bus0, e.data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ready1) begin
      if (q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_beat1: got ready=1 expected no beat at %0t", $time);
      end else begin
        e = q1.pop_front();
        chk("last1", 32'(last1), 32'(e.last));
        if (e.chk) chk("rd_data1", bus1, e.data);
      end
    end
  end

  task automatic push_exp(input int k, input logic [31:0] d, input logic c, input logic l);
    exp_t e;
    e.data = d; e.chk = c; e.last = l;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // abort_beat < 0 means no abort; poke_start pulses start during beat index 1.
  task automatic burst(input int k, input bit w, input logic [9:0] a, input int len,
                       input logic [31:0] d [4], input int abort_beat, input bit poke_start);
    int ws, n, busy_n, nbeats;
    ws     = (k == 0) ? 1 : 0;
    nbeats = (abort_beat >= 0) ? abort_beat + 1 : len + 1;
    for (int i = 0; i < nbeats; i++) push_exp(k, d[i], !w, i == len);
    @(negedge clk);
    start_s[k] = 1'b1; wr_s[k] = w; addr_s[k] = a; len_s[k] = 4'(len);
    @(negedge clk);
    start_s[k] = 1'b0;
    n = 1; busy_n = 0;
    while (!ready_of(k) && n < 20) begin
      if (busy_of(k)) busy_n++;
      @(negedge clk);
      n++;
    end
    chk("first_ready_delay", n, ws + 1);
    for (int i = 0; i < nbeats; i++) begin
      if (busy_of(k)) busy_n++;
      if (w) begin drv_s[k] = 1'b1; dval_s[k] = d[i]; end
      if (i == abort_beat) abort_s[k] = 1'b1;
      if (poke_start && i == 1) begin start_s[k] = 1'b1; addr_s[k] = 10'h000; end
      @(negedge clk);
      abort_s[k] = 1'b0;
      start_s[k] = 1'b0;
    end
    drv_s[k] = 1'b0;
    #1;
    chk("busy_cycles", busy_n, ws + nbeats);
    chk("idle_after_burst", 32'(busy_of(k)), 32'd0);
    chk("bus_released", bus_of(k), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] da [4];
    logic [31:0] db [4];
    logic [31:0] dc [4];
    logic [31:0] dx [4];
    da = '{32'hA000_00A0, 32'hA111_00A1, 32'hA222_00A2, 32'hA333_00A3};
    db = '{32'hB000_00B0, 32'hB111_00B1, 32'hB222_00B2, 32'hB333_00B3};
    dc = '{32'hC000_00C0, 32'hC111_00C1, 32'hC222_00C2, 32'hC333_00C3};

    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 0; wr_s[k] = 0; addr_s[k] = '0; len_s[k] = '0;
      abort_s[k] = 0; drv_s[k] = 0; dval_s[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_ready0", 32'(ready0), 32'd0);
    chk("rst_last0", 32'(last0), 32'd0);
    chk("rst_perr0", 32'(perr0), 32'd0);
    chk("rst_bus0", bus0, 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    rst = 1'b0;

    // wrapping write then read-back across the top of memory
    burst(0, 1'b1, 10'h3FE, 3, da, -1, 1'b0);
    burst(0, 1'b0, 10'h3FE, 3, da, -1, 1'b0);
    dx = '{da[2], da[3], 32'h0, 32'h0};
    burst(0, 1'b0, 10'h000, 1, dx, -1, 1'b0);

    // aborted write on beat 3, with an ignored start during beat 2
    burst(0, 1'b1, 10'h010, 3, db, -1, 1'b0);
    burst(0, 1'b1, 10'h010, 3, dc, 2, 1'b1);
    dx = '{dc[0], dc[1], db[2], db[3]};
    burst(0, 1'b0, 10'h010, 3, dx, -1, 1'b0);

    // asynchronous reset in the middle of a read burst
    push_exp(0, da[0], 1'b1, 1'b0);
    push_exp(0, da[1], 1'b1, 1'b0);
    @(negedge clk);
    start_s[0] = 1'b1; wr_s[0] = 1'b0; addr_s[0] = 10'h3FE; len_s[0] = 4'd3;
    @(negedge clk);
    start_s[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_ready", 32'(ready0), 32'd0);
    chk("midrst_bus", bus0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    burst(0, 1'b0, 10'h3FE, 3, da, -1, 1'b0);

    // zero wait states, single-beat burst
    dx = '{da[3], 32'h0, 32'h0, 32'h0};
    burst(1, 1'b1, 10'h001, 0, dx, -1, 1'b0);
    burst(1, 1'b0, 10'h001, 0, dx, -1, 1'b0);

`ifdef BURST_RAM_PARITY_EN
    dut0.mem_q[10'h3FE] = dut0.mem_q[10'h3FE] ^ 33'h1;
    dx = '{da[0] ^ 32'h1, 32'h0, 32'h0, 32'h0};
    burst(0, 1'b0, 10'h3FE, 0, dx, -1, 1'b0);
    chk("perr_set", 32'(perr0), 32'd1);
    dx = '{da[1], 32'h0, 32'h0, 32'h0};
    burst(0, 1'b0, 10'h3FF, 0, dx, -1, 1'b0);
    chk("perr_sticky", 32'(perr0), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("perr_cleared", 32'(perr0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("queue0_drained", q0.size(), 32'd0);
    chk("queue1_drained", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_ram.md
Name: burst_ram

Overview:
- Parametrised successor to the shared-bus word RAM: single-port memory on the tri-state system bus, generalised in data width and depth.
- Adds a burst engine with an auto-incrementing, wrapping address counter, programmable wait states, an abort input and a ready/last handshake.
- Sits between the control unit and the shared bus. The control unit issues one start pulse per burst instead of sequencing every word.

Parameters:
- DATA_W, 32, bus and word width in bits.
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W words.
- WAIT_STATES, 1, idle cycles between burst acceptance and the first beat (0..15).
- LEN_W, 4, burst length field width; a burst is burst_len+1 beats.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  burst request, sampled in IDLE only
- wr  in  1  direction, sampled with start: 1 = bus->memory, 0 = memory->bus
- addr  in  ADDR_W  burst start address, sampled with start
- burst_len  in  LEN_W  beats minus one, sampled with start
- abort  in  1  terminate current burst
- bus  inout  DATA_W  shared tri-state data bus (pulled low when undriven)
- busy  out  1  high in every state except IDLE
- ready  out  1  high during each data beat
- last  out  1  high during the final beat of a burst
- parity_err  out  1  sticky read parity error (only with the optional feature)

Behaviour:
- Reset (async, any state): FSM -> IDLE; busy, ready, last and parity_err = 0; bus released (Z); address, beat and wait counters = 0. Memory contents are neither cleared nor altered.
- States: IDLE, WAIT, XFER.
- IDLE:
  - start=1 at a posedge latches addr->ptr, wr->dir, burst_len->beats.
  - Next state is WAIT if WAIT_STATES>0, else XFER; wait counter loads WAIT_STATES-1.
- WAIT:
  - Counter decrements each cycle; at 0 -> XFER.
  - Exactly WAIT_STATES cycles are spent in WAIT.
- XFER: one beat per cycle, ready=1.
  - Read (dir=0): bus = mem[ptr], combinational from ptr, valid for the whole beat.
  - Write (dir=1): mem[ptr] <= bus at the posedge closing the beat.
  - Each beat: ptr <= ptr+1, modulo DEPTH (DEPTH-1 wraps to 0); beats <= beats-1.
  - last=1 when beats==0; that beat's closing posedge -> IDLE.
- Latency: start sampled at edge N; first beat occupies cycle N+1+WAIT_STATES; a burst takes burst_len+1 consecutive beats with no bubbles.
- burst_len=0: single beat with ready=1 and last=1 together.
- Bus drive: the block drives bus only when state==XFER and dir=0; otherwise Z.
- start while busy: ignored, no queuing. The FSM needs at least one IDLE cycle between bursts.
- abort=1 in WAIT or XFER:
  - Next state IDLE.
  - The beat during which abort is high does not write memory and does not advance ptr.
  - The bus is still driven during that read beat (combinational).
  - abort in IDLE has no effect; abort has priority over start in the same cycle.
- Reset mid-burst: remaining beats are dropped and earlier written words persist. An asserted write beat coinciding with reset assertion is not written.

Optional Feature:
- Macro: BURST_RAM_PARITY_EN.
- Enabled:
  - Memory word is DATA_W+1 bits; the extra bit stores even parity (XOR of data) on each write beat.
  - On each read beat, a stored parity mismatch sets parity_err, which stays high until rst.
- Disabled: memory is DATA_W bits wide and parity_err is tied to 0.

Test Plan:
- WAIT_STATES=1, write burst start addr=0x3FE, burst_len=3, bus=A0,A1,A2,A3 on consecutive beats -> mem[0x3FE]=A0, mem[0x3FF]=A1, mem[0x000]=A2, mem[0x001]=A3; ready first rises 2 cycles after the start edge; last only on beat 4.
- Read burst addr=0x3FE, burst_len=3 -> bus shows A0,A1,A2,A3 on 4 consecutive ready beats; bus is Z (reads 0 via pulldown) outside XFER; busy high for 5 cycles.
- burst_len=0, WAIT_STATES=0, read addr=0x001 -> exactly one beat, ready=last=1, bus=A3, back to IDLE next cycle.
- Write burst of 4 to 0x010 with abort=1 on beat 3 -> only 0x010 and 0x011 written, 0x012/0x013 unchanged; IDLE next cycle. A start pulsed during beat 2 is ignored.
- rst asserted mid-read burst (asynchronous, between edges) -> bus Z and busy=0 immediately; a later read shows previously written data intact.
- BURST_RAM_PARITY_EN: force-flip a stored data bit, then read that word -> parity_err=1 and remains 1 through later clean reads until rst.
